checksum_accum: RTL and testbench
=================================

# checksum_accum

Parametrised streaming 16-bit ones'-complement (Internet) checksum engine. It accepts a packet as a sequence of multi-lane beats over a valid/ready handshake and folds end-around carries every beat, so the accumulator never overflows. On the last beat it produces the complemented checksum and a verify flag. It sits in the packet datapath beside the header builder: in generate mode it produces the header checksum, and in check mode it validates received headers.

## Interface
- `LANES`, default 2: number of 16-bit words per beat, 1..8. Lane 0 is `in_data[15:0]`.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `init_sum`, input, 16: seed (e.g. pseudo-header partial sum), sampled on the first accepted beat of each packet.
- `in_valid`, input, 1: beat present.
- `in_ready`, output, 1: engine accepts a beat this cycle.
- `in_data`, input, 16*LANES: packet words.
- `in_keep`, input, LANES: per-lane enable; a disabled lane contributes 0x0000.
- `in_last`, input, 1: final beat of the packet.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer takes the result.
- `out_sum`, output, 16: `~(ones'-complement sum)`.
- `out_ok`, output, 1: high when the ones'-complement sum equals 0xFFFF, which is a valid received checksum.

## Operation
- FSM states: ACCUM, FINAL, DONE. Reset state is ACCUM.
- `first` flag: set at reset and on every result handoff; cleared on an accepted non-last beat.
- ACCUM:
  - `in_ready` = 1.
  - An accepted beat (`in_valid & in_ready`) computes `lane_sum`, the sum of masked lanes, width 16+clog2(LANES+1).
  - `base` = `init_sum` if `first`, else `acc`.
  - `acc <= fold(fold(base + lane_sum))`, where `fold(x)` = `x[15:0] + x[MSB:16]`. The result is always 16 bits.
  - If `in_last` is set, go to FINAL.
- FINAL:
  - `in_ready` = 0.
  - Register `out_sum <= ~acc` and `out_ok <= (acc == 16'hFFFF)`.
  - Go to DONE.
- DONE:
  - `out_valid` = 1 and `in_ready` = 0.
  - `out_sum` and `out_ok` are held stable until `out_valid & out_ready`.
  - On that handoff: go to ACCUM, set `first`, clear `acc`.
- Arithmetic rules:
  - 0xFFFF and 0x0000 are both legal intermediate values. No normalisation of negative zero.
  - A beat with `in_keep` = 0 is legal and leaves `acc` unchanged, apart from loading the seed if `first`.
- Boundary conditions:
  - A single-beat packet (`first` and `in_last` together) uses `init_sum` as the base.
  - `in_valid` without `in_ready` (FINAL/DONE) has no effect; the upstream holds the beat.
  - `out_ready` high while `out_valid` is low is ignored.
  - Reset asserted mid-packet or mid-DONE discards all state immediately.

## Timing
- Reset values:
  - `in_ready` = 1
  - `out_valid` = 0
  - `out_sum` = 0x0000
  - `out_ok` = 0
  - `acc` = 0x0000
  - state = ACCUM
  - `first` = 1
- Latency:
  - The last beat is accepted at edge k.
  - FINAL occupies cycle k→k+1.
  - `out_valid` rises after edge k+1.
- Throughput:
  - One beat per cycle within a packet.
  - At least 2 dead cycles between packets, plus any `out_ready` stall.
- `in_ready` is a registered state decode, with no combinational path from `out_ready`.

## Structure
- The shared package `checksum_pkg` holds:
  - `WORD_W` = 16
  - `ONES_ZERO_OK` = 16'hFFFF
  - a `fold16` function
  - the state enum `cs_state_t`
- One natural sub-module, `csum_lane_adder`, implements the combinational masked LANES-input adder tree. It is parameterised by `LANES` and also reused by the header builder.

## Test plan
- RFC 1071 example, LANES=2, `init_sum`=0:
  - Stimulus: beats 0xF2030001 then 0xF6F7F4F5 (`last`), `keep`=11.
  - Required: `out_sum`=0x220D, `out_ok`=0, `out_valid` exactly 2 edges after the last beat.
- Verify:
  - Stimulus: the same packet plus a third beat 0x0000220D with `keep`=01 and `last`.
  - Required: `out_sum`=0x0000, `out_ok`=1.
- Seed and wrap-around:
  - Stimulus: `init_sum`=0xFFFF, single beat 0x00000001 with `keep`=01 and `last`.
  - Required: `acc` 0x10000 folds to 0x0001, so `out_sum`=0xFFFE, `out_ok`=0.
- Back-pressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles after `out_valid`.
  - Required: `out_sum`/`out_ok` stable, `in_ready`=0 throughout. After the handoff, a new packet 0x00010001 (`last`) with `init_sum`=0 gives 0xFFFD, which proves `acc` and `first` were reset.
- Reset mid-packet:
  - Stimulus: assert `rst_n`=0 asynchronously after one non-last beat, release, then send single beat 0x00000000 with `keep`=11 and `last`.
  - Required: `out_sum`=0xFFFF, `out_ok`=0, with no residue from the aborted packet.
- LANES=8 stress:
  - Stimulus: one beat of all-0xFFFF with `keep`=0xFF and `last`.
  - Required: `out_sum`=0x0000, `out_ok`=1.

Source files
------------

// File: rtl/checksum_pkg.sv
// Shared definitions for the ones'-complement checksum datapath.
package checksum_pkg;

    localparam int unsigned WORD_W       = 16;
    localparam logic [15:0] ONES_ZERO_OK = 16'hFFFF;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FINAL = 2'd1,
        DONE  = 2'd2
    } cs_state_t;

    // One end-around-carry fold: low word plus everything above it.
    function automatic logic [31:0] fold16(input logic [31:0] x);
        return {16'h0000, x[15:0]} + {16'h0000, x[31:16]};
    endfunction

endpackage

// File: rtl/csum_lane_adder.sv
// Combinational masked adder over LANES 16-bit words; disabled lanes add zero.
module csum_lane_adder
    import checksum_pkg::*;
#(
    parameter int unsigned LANES = 2
) (
    input  logic [WORD_W*LANES-1:0]                data,
    input  logic [LANES-1:0]                       keep,
    output logic [WORD_W+$clog2(LANES+1)-1:0]      sum
);

    localparam int unsigned SUM_W = WORD_W + $clog2(LANES + 1);

    // Sum of the kept lanes, wide enough that no carry is lost.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (keep[i]) begin
                sum = sum + SUM_W'(data[i*WORD_W +: WORD_W]);
            end
        end
    end

endmodule

// File: rtl/checksum_accum.sv
// Streaming 16-bit ones'-complement checksum engine with valid/ready in and out.
module checksum_accum
    import checksum_pkg::*;
#(
    parameter int unsigned LANES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             init_sum,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [16*LANES-1:0]     in_data,
    input  logic [LANES-1:0]        in_keep,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             out_sum,
    output logic                    out_ok
);

    localparam int unsigned SUM_W = WORD_W + $clog2(LANES + 1);

    cs_state_t          state;
    cs_state_t          state_nxt;
    logic               first;
    logic [15:0]        acc;
    logic [15:0]        base;
    logic [15:0]        acc_nxt;
    logic [31:0]        total;
    logic [SUM_W-1:0]   lane_sum;
    logic               accept;
    logic               handoff;

    csum_lane_adder #(
        .LANES (LANES)
    ) u_lane_adder (
        .data (in_data),
        .keep (in_keep),
        .sum  (lane_sum)
    );

    // Next accumulator: seed or running sum plus this beat, folded twice so
    // every carry, including the one produced by the first fold, wraps back.
    always_comb begin
        base    = first ? init_sum : acc;
        total   = 32'(base) + 32'(lane_sum);
        acc_nxt = 16'(fold16(fold16(total)));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; ready/valid depend only on state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_nxt = FINAL;
                end
            end
            FINAL: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

    assign accept  = in_valid & in_ready;
    assign handoff = out_valid & out_ready;

    // Accumulator, first-beat flag and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            first   <= 1'b1;
            out_sum <= '0;
            out_ok  <= 1'b0;
        end else begin
            if (accept) begin
                acc <= acc_nxt;
                if (!in_last) begin
                    first <= 1'b0;
                end
            end
            if (state == FINAL) begin
                out_sum <= ~acc;
                out_ok  <= (acc == ONES_ZERO_OK);
            end
            if (handoff) begin
                acc   <= '0;
                first <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_checksum_accum.sv
// Directed self-checking bench for checksum_accum (LANES=2 and LANES=8).
module tb_checksum_accum;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] init_sum;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_keep;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_ok;

    logic [15:0]  d8_init;
    logic         d8_in_valid;
    logic         d8_in_ready;
    logic [127:0] d8_in_data;
    logic [7:0]   d8_in_keep;
    logic         d8_in_last;
    logic         d8_out_valid;
    logic         d8_out_ready;
    logic [15:0]  d8_out_sum;
    logic         d8_out_ok;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    checksum_accum #(.LANES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_sum  (init_sum),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ok    (out_ok)
    );

    checksum_accum #(.LANES(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_sum  (d8_init),
        .in_valid  (d8_in_valid),
        .in_ready  (d8_in_ready),
        .in_data   (d8_in_data),
        .in_keep   (d8_in_keep),
        .in_last   (d8_in_last),
        .out_valid (d8_out_valid),
        .out_ready (d8_out_ready),
        .out_sum   (d8_out_sum),
        .out_ok    (d8_out_ok)
    );

    typedef struct {
        string            name;
        logic [15:0]      init;
        int               nb;
        logic [2:0][31:0] data;
        logic [2:0][1:0]  keep;
        logic [15:0]      exp_sum;
        logic             exp_ok;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [15:0] init, input int nb,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [1:0] k0, input logic [1:0] k1, input logic [1:0] k2,
                                input logic [15:0] es, input logic eo);
        vec_t v;
        v.name = name; v.init = init; v.nb = nb;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
        v.keep[0] = k0; v.keep[1] = k1; v.keep[2] = k2;
        v.exp_sum = es; v.exp_ok = eo;
        return v;
    endfunction

    // Present one beat on the negative edge; it is accepted on the next rising edge.
    task automatic send_beat(input logic [15:0] init, input logic [31:0] data,
                             input logic [1:0] keep, input logic last);
        @(negedge clk);
        check("in_ready_accum", 32'(in_ready), 32'd1);
        init_sum = init; in_data = data; in_keep = keep; in_last = last; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Count edges from the accepting edge (inclusive) until out_valid is seen.
    task automatic wait_result(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!seen) begin
            check("out_valid_timeout", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_handoff", 32'(out_valid), 32'd0);
    endtask

    task automatic d8_packet(input string name, input logic [127:0] data, input logic [7:0] keep,
                             input logic [15:0] es, input logic eo);
        bit seen;
        @(negedge clk);
        check({name, "_in_ready"}, 32'(d8_in_ready), 32'd1);
        d8_init = 16'h0000; d8_in_data = data; d8_in_keep = keep; d8_in_last = 1'b1; d8_in_valid = 1'b1;
        @(posedge clk);
        #1;
        d8_in_valid = 1'b0;
        d8_in_last  = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (d8_out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_valid"}, 32'(seen), 32'd1);
        check({name, "_sum"}, 32'(d8_out_sum), 32'(es));
        check({name, "_ok"}, 32'(d8_out_ok), 32'(eo));
        d8_out_ready = 1'b1;
        @(posedge clk);
        #1;
        d8_out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [15:0] held_sum;

        rst_n = 1'b0;
        init_sum = '0; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0; out_ready = 1'b0;
        d8_init = '0; d8_in_valid = 1'b0; d8_in_data = '0; d8_in_keep = '0; d8_in_last = 1'b0; d8_out_ready = 1'b0;

        vecs[0] = mk("rfc1071",   16'h0000, 2, 32'hF2030001, 32'hF6F7F4F5, 32'h0,        2'b11, 2'b11, 2'b00, 16'h220D, 1'b0);
        vecs[1] = mk("verify",    16'h0000, 3, 32'hF2030001, 32'hF6F7F4F5, 32'h0000220D, 2'b11, 2'b11, 2'b01, 16'h0000, 1'b1);
        vecs[2] = mk("seed_wrap", 16'hFFFF, 1, 32'h00000001, 32'h0,        32'h0,        2'b01, 2'b00, 2'b00, 16'hFFFE, 1'b0);
        vecs[3] = mk("keep_zero", 16'h1234, 1, 32'hABCDEF01, 32'h0,        32'h0,        2'b00, 2'b00, 2'b00, 16'hEDCB, 1'b0);
        vecs[4] = mk("mask_hi",   16'h0000, 1, 32'h11112222, 32'h0,        32'h0,        2'b01, 2'b00, 2'b00, 16'hDDDD, 1'b0);
        vecs[5] = mk("carry2",    16'h0000, 2, 32'h0001FFFF, 32'h80008000, 32'h0,        2'b11, 2'b11, 2'b00, 16'hFFFD, 1'b0);
        vecs[6] = mk("ok_hi",     16'h0000, 1, 32'hFFFF0000, 32'h0,        32'h0,        2'b10, 2'b00, 2'b00, 16'h0000, 1'b1);
        vecs[7] = mk("seed_once", 16'h5555, 2, 32'h00000001, 32'h00000001, 32'h0,        2'b01, 2'b01, 2'b00, 16'hAAA8, 1'b0);
        vecs[8] = mk("mid_keep0", 16'h0000, 3, 32'h00000010, 32'h00000020, 32'h00000030, 2'b01, 2'b00, 2'b01, 16'hFFBF, 1'b0);

        // Reset values.
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'h0);
        check("rst_out_ok", 32'(out_ok), 32'd0);
        check("rst8_out_valid", 32'(d8_out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of packets.
        for (int v = 0; v < 9; v++) begin
            for (int b = 0; b < vecs[v].nb; b++) begin
                send_beat(vecs[v].init, vecs[v].data[b], vecs[v].keep[b], b == vecs[v].nb - 1);
            end
            wait_result(lat);
            check({vecs[v].name, "_latency"}, 32'(lat), 32'd2);
            check({vecs[v].name, "_sum"}, 32'(out_sum), 32'(vecs[v].exp_sum));
            check({vecs[v].name, "_ok"}, 32'(out_ok), 32'(vecs[v].exp_ok));
            take_result();
        end

        // Back-pressure: result held, no beat accepted while DONE stalls.
        send_beat(16'h0000, 32'hF2030001, 2'b11, 1'b0);
        send_beat(16'h0000, 32'hF6F7F4F5, 2'b11, 1'b1);
        wait_result(lat);
        held_sum = out_sum;
        check("bp_first_sum", 32'(held_sum), 32'h220D);
        in_valid = 1'b1; in_data = 32'h12345678; in_keep = 2'b11; in_last = 1'b1; init_sum = 16'h4444;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum_stable", 32'(out_sum), 32'h220D);
            check("bp_ok_stable", 32'(out_ok), 32'd0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        take_result();
        // out_ready held high while out_valid is low must not disturb the next packet.
        out_ready = 1'b1;
        send_beat(16'h0000, 32'h00010001, 2'b11, 1'b1);
        wait_result(lat);
        check("bp_after_sum", 32'(out_sum), 32'hFFFD);
        check("bp_after_ok", 32'(out_ok), 32'd0);
        check("bp_after_lat", 32'(lat), 32'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_after_handoff", 32'(out_valid), 32'd0);

        // Reset mid-packet.
        send_beat(16'h1111, 32'h12345678, 2'b11, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_out_sum", 32'(out_sum), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(16'h0000, 32'h00000000, 2'b11, 1'b1);
        wait_result(lat);
        check("rstmid_sum", 32'(out_sum), 32'hFFFF);
        check("rstmid_ok", 32'(out_ok), 32'd0);
        take_result();

        // Reset while DONE.
        send_beat(16'h0000, 32'hFFFF0000, 2'b11, 1'b1);
        wait_result(lat);
        check("rstdone_pre_ok", 32'(out_ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstdone_out_valid", 32'(out_valid), 32'd0);
        check("rstdone_in_ready", 32'(in_ready), 32'd1);
        check("rstdone_out_sum", 32'(out_sum), 32'h0);
        check("rstdone_out_ok", 32'(out_ok), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LANES=8 instance.
        d8_packet("l8_all_ones", {8{16'hFFFF}}, 8'hFF, 16'h0000, 1'b1);
        d8_packet("l8_masked", {16'h2000, {6{16'hFFFF}}, 16'h1000}, 8'h81, 16'hCFFF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
